// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode bit positions, the four mode encodings and
// the slave FSM state type. Also used by spi_master.
package spi_pkg;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_BYTE_DONE = 2'd2
  } slave_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizer chain for an asynchronous pin, followed by rise/fall detection
// on the synchronized level. RESET_VAL is the pin's idle level, so that
// reset does not produce a spurious edge.
module spi_pin_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the pin through the chain and keep one extra delayed copy for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI slave, all four modes, MSB first, oversampled pins.
// Optional feature: define SPI_SLAVE_OVERRUN_EN to add the sticky rx_overrun
// flag, set when a byte completes before the previous one was acknowledged.
module spi_slave
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss,
  output logic       miso,
  output logic       miso_oe
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic       rx_overrun
`endif
);

  slave_state_t state, next_state;

  logic       sclk_level, sclk_rise, sclk_fall;
  logic       ss_level, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic       mosi_s;

  logic [1:0] mode_q;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] hold;
  logic       hold_full;

  logic       transfer;
  logic [7:0] reload_byte;
  logic       sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .pin(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .pin(ss),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  // mosi only needs to be stable when an sclk edge is seen, so no edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_chain <= '0;
    else      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  // An edge moving sclk away from its idle level (CPOL) is the leading edge
  assign sclk_edge   = sclk_rise | sclk_fall;
  assign lead_edge   = sclk_edge & (sclk_level != mode_q[CPOL_BIT]);
  assign trail_edge  = sclk_edge & (sclk_level == mode_q[CPOL_BIT]);
  assign sample_edge = mode_q[CPHA_BIT] ? trail_edge : lead_edge;
  assign shift_edge  = mode_q[CPHA_BIT] ? lead_edge : trail_edge;

  assign transfer    = tx_valid & ~hold_full;
  assign tx_ready    = ~hold_full;
  assign reload_byte = hold_full ? hold : IDLE_BYTE;
  assign miso_oe     = ~ss_level;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next-state decode and the receive strobe
  always_comb begin
    next_state = state;
    rx_valid   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ss_fall) next_state = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (ss_rise) next_state = ST_IDLE;
        else if (sample_edge && bit_cnt == 3'd7) next_state = ST_BYTE_DONE;
      end
      ST_BYTE_DONE: begin
        rx_valid   = 1'b1;
        next_state = ss_level ? ST_IDLE : ST_ACTIVE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Shifters, bit counter, holding register and miso
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= 2'b00;
      bit_cnt   <= 3'd0;
      rx_shift  <= 8'h00;
      tx_shift  <= 8'h00;
      rx_data   <= 8'h00;
      hold      <= 8'h00;
      hold_full <= 1'b0;
      miso      <= 1'b0;
    end else begin
      if (transfer) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (ss_fall) begin
            mode_q  <= mode;
            bit_cnt <= 3'd0;
            miso    <= reload_byte[7];
            // CPHA=0 has bit 7 already on miso, so the shifter starts at bit 6
            tx_shift <= mode[CPHA_BIT] ? reload_byte : {reload_byte[6:0], 1'b0};
            if (hold_full) hold_full <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (ss_rise) begin
            bit_cnt <= 3'd0;
          end else begin
            if (sample_edge) begin
              rx_shift <= {rx_shift[6:0], mosi_s};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) rx_data <= {rx_shift[6:0], mosi_s};
            end
            if (shift_edge) begin
              miso     <= tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
        end
        ST_BYTE_DONE: begin
          // Next shift edge presents bit 7 in both phases, so load unshifted
          tx_shift <= reload_byte;
          if (hold_full) hold_full <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_pending;

  // Track unacknowledged bytes; a second completion while pending is sticky overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_pending <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (state == ST_BYTE_DONE) begin
      if (rx_pending) rx_overrun <= 1'b1;
      rx_pending <= 1'b1;
    end else if (transfer || ss_level) begin
      rx_pending <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged SPI master drives the pins and
// hand-computed bytes are compared in both directions.
module tb_spi_slave;

  localparam int HALF = 8;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       sclk;
  logic       mosi;
  logic       ss;
  logic       miso;
  logic       miso_oe;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       rx_overrun;
`endif

  int checks   = 0;
  int failures = 0;
  int rx_count = 0;
  logic [7:0] rx_log [16];

  spi_slave dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .sclk(sclk),
    .mosi(mosi),
    .ss(ss),
    .miso(miso),
    .miso_oe(miso_oe)
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    .rx_overrun(rx_overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every receive strobe cycle together with the byte it presents
  always @(negedge clk) begin
    if (rst && rx_valid === 1'b1) begin
      rx_log[rx_count[3:0]] = rx_data;
      rx_count = rx_count + 1;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setMode(input logic [1:0] m);
    mode = m;
    sclk = m[1];
    waitClk(HALF);
  endtask

  task automatic ssLow();
    ss = 1'b0;
    waitClk(HALF);
  endtask

  task automatic ssHigh();
    waitClk(HALF);
    ss = 1'b1;
    waitClk(HALF);
  endtask

  task automatic offerByte(input logic [7:0] d);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    checkOutput("tx_ready_after_offer", {31'd0, tx_ready}, 32'd0);
  endtask

  // Master side of nbits bit times, MSB first, for the given mode
  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] tx, input int nbits,
                               output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!m[0]) begin
        mosi = tx[i];
        waitClk(HALF);
        sclk = ~m[1];
        rx[i] = miso;
        waitClk(HALF);
        sclk = m[1];
      end else begin
        sclk = ~m[1];
        mosi = tx[i];
        waitClk(HALF);
        sclk = m[1];
        rx[i] = miso;
        waitClk(HALF);
      end
    end
  endtask

  task automatic singleFrame(input string tag, input logic [1:0] m, input bit offer,
                             input logic [7:0] slave_byte, input logic [7:0] master_byte,
                             input logic [7:0] expect_miso);
    logic [7:0] got;
    int base;
    setMode(m);
    if (offer) offerByte(slave_byte);
    base = rx_count;
    ssLow();
    applyStimulus(m, master_byte, 8, got);
    ssHigh();
    checkOutput({tag, "_miso_byte"}, {24'd0, got}, {24'd0, expect_miso});
    checkOutput({tag, "_rx_count"}, rx_count - base, 32'd1);
    checkOutput({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, master_byte});
    checkOutput({tag, "_oe_idle"}, {31'd0, miso_oe}, 32'd0);
  endtask

  initial begin
    logic [7:0] got0, got1;
    int base;

    rst = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; mode = 2'b00;
    tx_valid = 1'b0; tx_data = 8'h00;
    waitClk(3);
    checkOutput("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'h00);
    checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_miso", {31'd0, miso}, 32'd0);
    checkOutput("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
    rst = 1'b1;
    waitClk(4);

    // Mode 0, slave A5, master DD; also check miso_oe and tx_ready around ss fall
    setMode(2'b00);
    offerByte(8'hA5);
    base = rx_count;
    ssLow();
    checkOutput("m0_oe_active", {31'd0, miso_oe}, 32'd1);
    checkOutput("m0_tx_ready_consumed", {31'd0, tx_ready}, 32'd1);
    applyStimulus(2'b00, 8'hDD, 8, got0);
    ssHigh();
    checkOutput("m0_miso_byte", {24'd0, got0}, 32'hA5);
    checkOutput("m0_rx_count", rx_count - base, 32'd1);
    checkOutput("m0_rx_data", {24'd0, rx_data}, 32'hDD);
    checkOutput("m0_oe_idle", {31'd0, miso_oe}, 32'd0);

    singleFrame("m1", 2'b01, 1'b1, 8'h3C, 8'hC3, 8'h3C);
    singleFrame("m3", 2'b11, 1'b1, 8'h3C, 8'hC3, 8'h3C);
    singleFrame("m2", 2'b10, 1'b1, 8'h96, 8'h69, 8'h96);
    singleFrame("empty", 2'b00, 1'b0, 8'h00, 8'h12, 8'hFF);

    // Two bytes in one frame, second offered while byte 1 shifts
    setMode(2'b00);
    offerByte(8'h01);
    base = rx_count;
    ssLow();
    fork
      applyStimulus(2'b00, 8'h5A, 8, got0);
      begin
        waitClk(20);
        offerByte(8'h02);
      end
    join
    applyStimulus(2'b00, 8'hC7, 8, got1);
    ssHigh();
    checkOutput("multi_miso_b0", {24'd0, got0}, 32'h01);
    checkOutput("multi_miso_b1", {24'd0, got1}, 32'h02);
    checkOutput("multi_rx_count", rx_count - base, 32'd2);
    checkOutput("multi_rx_b0", {24'd0, rx_log[base[3:0]]}, 32'h5A);
    checkOutput("multi_rx_b1", {24'd0, rx_data}, 32'hC7);

    // Abort after 3 bit times, then a clean frame
    setMode(2'b00);
    base = rx_count;
    ssLow();
    applyStimulus(2'b00, 8'hE0, 3, got0);
    ssHigh();
    checkOutput("abort_rx_count", rx_count - base, 32'd0);
    checkOutput("abort_rx_data_held", {24'd0, rx_data}, 32'hC7);
    singleFrame("after_abort", 2'b00, 1'b0, 8'h00, 8'h77, 8'hFF);

    // Reset in the middle of a byte with miso high and the holding register full
    setMode(2'b00);
    offerByte(8'hFF);
    ssLow();
    offerByte(8'h33);
    applyStimulus(2'b00, 8'h00, 4, got0);
    waitClk(6);
    checkOutput("pre_reset_miso", {31'd0, miso}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("midreset_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("midreset_rx_data", {24'd0, rx_data}, 32'h00);
    checkOutput("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("midreset_miso", {31'd0, miso}, 32'd0);
    checkOutput("midreset_miso_oe", {31'd0, miso_oe}, 32'd0);
`ifdef SPI_SLAVE_OVERRUN_EN
    checkOutput("midreset_overrun", {31'd0, rx_overrun}, 32'd0);
`endif
    ss = 1'b1;
    sclk = 1'b0;
    waitClk(4);
    rst = 1'b1;
    waitClk(4);

`ifdef SPI_SLAVE_OVERRUN_EN
    // Two unacknowledged bytes in one frame
    setMode(2'b00);
    ssLow();
    applyStimulus(2'b00, 8'h11, 8, got0);
    applyStimulus(2'b00, 8'h22, 8, got1);
    ssHigh();
    checkOutput("overrun_set", {31'd0, rx_overrun}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
